// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the multi-cycle CPU.
//
// Keeps a fetch PC, issues one memory read at a time and buffers the
// returned {pc, instruction} pairs in a small circular prefetch queue
// that feeds the decoder. Redirects (relative branch, absolute jump,
// return through the link register) flush the queue and retarget fetch.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   mem_cmd         2'b01 (read) while a request is outstanding, else 2'b00
//   mem_addr        address of the outstanding request, 0 when idle
//   mem_ready       read_data is valid for the outstanding request
//   read_data       memory read data
//   ir_valid        queue head is valid
//   ir_data, ir_pc  queue head instruction and its address (0 when empty)
//   ir_ready        decoder consumes the head this cycle
//   redirect        one-cycle redirect strobe
//   redirect_mode   00 relative, 01 absolute, 10 return, 11 as relative
//   branch_pc       pc of the redirecting instruction
//   redirect_off    sign-extended relative offset
//   redirect_tgt    absolute target
//   redirect_link   with redirect: link <= branch_pc + 1
//   link_out        current link register value
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding; issues one when the queue has room
// FETCH | read outstanding at req_addr; data is queued on mem_ready
// DROP  | read outstanding but a redirect made it stale; data discarded

module fetch_unit #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [1:0]        redirect_mode,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [ADDR_W-1:0] redirect_off,
  input  logic [ADDR_W-1:0] redirect_tgt,
  input  logic              redirect_link,
  output logic [ADDR_W-1:0] link_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] link_q;
  logic [ADDR_W-1:0] target;

  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after_pop;
  logic [CNT_W-1:0]  count_after_push;

  logic pop, push, issue;

  // Redirect beats both queue operations in the same cycle.
  assign pop              = (count != '0) && ir_ready && !redirect;
  assign push             = (state == FETCH) && mem_ready && !redirect;
  assign count_after_pop  = count - CNT_W'(pop);
  assign count_after_push = count_after_pop + CNT_W'(push);

  // A request is only issued when its data is guaranteed a slot, so a
  // push can never land on a full queue.
  assign issue = (state == IDLE) && !redirect && (count_after_pop < DEPTH_C);

  // Return uses the link value from before any same-cycle link write.
  always_comb begin
    target = branch_pc + ADDR_W'(1) + redirect_off;
    case (redirect_mode)
      2'b01:   target = redirect_tgt;
      2'b10:   target = link_q;
      default: target = branch_pc + ADDR_W'(1) + redirect_off;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue) state_nxt = FETCH;
      end
      FETCH: begin
        if (redirect)
          state_nxt = mem_ready ? IDLE : DROP;
        else if (mem_ready)
          state_nxt = (count_after_push < DEPTH_C) ? FETCH : IDLE;
      end
      DROP: begin
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_cmd  = 2'b00;
    mem_addr = '0;
    if (state == FETCH || state == DROP) begin
      mem_cmd  = 2'b01;
      mem_addr = req_addr;
    end
    ir_valid = (count != '0);
    ir_data  = ir_valid ? q_data[head] : '0;
    ir_pc    = ir_valid ? q_pc[head]   : '0;
    link_out = link_q;
  end

  // Fetch PC, request address and link register
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc      <= RESET_PC;
      req_addr <= '0;
      link_q   <= '0;
    end else begin
      if (redirect)
        fpc <= target;
      else if (push)
        fpc <= req_addr + ADDR_W'(1);

      // Back-to-back fetch: the next request follows the one completing.
      if (issue)
        req_addr <= fpc;
      else if (push && state_nxt == FETCH)
        req_addr <= req_addr + ADDR_W'(1);

      if (redirect && redirect_link)
        link_q <= branch_pc + ADDR_W'(1);
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count_after_push;
    end
  end

  // Queue storage; contents are only observed through count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= req_addr;
      q_data[tail] <= read_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [DW-1:0] read_data;
  logic          ir_valid;
  logic [DW-1:0] ir_data;
  logic [AW-1:0] ir_pc;
  logic          ir_ready;
  logic          redirect;
  logic [1:0]    redirect_mode;
  logic [AW-1:0] branch_pc;
  logic [AW-1:0] redirect_off;
  logic [AW-1:0] redirect_tgt;
  logic          redirect_link;
  logic [AW-1:0] link_out;

  int n_cmp      = 0;
  int n_fail     = 0;
  int n_consumed = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .mem_cmd       (mem_cmd),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .read_data     (read_data),
    .ir_valid      (ir_valid),
    .ir_data       (ir_data),
    .ir_pc         (ir_pc),
    .ir_ready      (ir_ready),
    .redirect      (redirect),
    .redirect_mode (redirect_mode),
    .branch_pc     (branch_pc),
    .redirect_off  (redirect_off),
    .redirect_tgt  (redirect_tgt),
    .redirect_link (redirect_link),
    .link_out      (link_out)
  );

  // Memory image: each word encodes its own address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 16'hA000 | {7'b0, a};
  endfunction

  assign read_data = mem_word(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: the decoder must see the instruction stream
  // target, target+1, ... starting at the latest redirect (or reset),
  // each with its memory word. Expected items are queued ahead and
  // popped whenever the DUT hands an instruction to the decoder.
  // ------------------------------------------------------------------
  logic [AW-1:0] sb [$];
  logic [AW-1:0] m_next;
  logic [AW-1:0] m_link;
  logic [AW-1:0] m_tgt;
  logic [AW-1:0] e_pc;
  logic          hold_exp = 1'b0;
  logic [AW-1:0] hold_addr;

  always @(negedge clk) begin
    chk("mem_cmd_legal", {31'b0, mem_cmd[1]}, 32'd0);
    if (hold_exp) begin
      chk("req_held_cmd", {30'b0, mem_cmd}, 32'd1);
      chk("req_held_addr", {23'b0, mem_addr}, {23'b0, hold_addr});
    end
    hold_exp  = (mem_cmd == 2'b01) && !mem_ready && !reset;
    hold_addr = mem_addr;

    if (reset) begin
      sb.delete();
      m_next = '0;
      m_link = '0;
    end else begin
      chk("link_out", {23'b0, link_out}, {23'b0, m_link});
      if (!ir_valid)
        chk("empty_head_zero", {7'b0, ir_pc, ir_data}, 32'd0);
      if (redirect) begin
        case (redirect_mode)
          2'b01:   m_tgt = redirect_tgt;
          2'b10:   m_tgt = m_link;
          default: m_tgt = AW'(branch_pc + 1 + redirect_off);
        endcase
        if (redirect_link) m_link = AW'(branch_pc + 1);
        sb.delete();
        m_next = m_tgt;
      end else if (ir_valid && ir_ready) begin
        e_pc = sb.pop_front();
        n_consumed++;
        chk("consume_pc", {23'b0, ir_pc}, {23'b0, e_pc});
        chk("consume_data", {16'b0, ir_data}, {16'b0, mem_word(e_pc)});
      end
    end
    while (sb.size() < 4) begin
      sb.push_back(m_next);
      m_next = m_next + AW'(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] mode, input logic [AW-1:0] bpc,
                        input logic [AW-1:0] off, input logic [AW-1:0] tgt,
                        input logic lnk);
    redirect      = 1'b1;
    redirect_mode = mode;
    branch_pc     = bpc;
    redirect_off  = off;
    redirect_tgt  = tgt;
    redirect_link = lnk;
    step();
    redirect      = 1'b0;
    redirect_link = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] held;

  initial begin
    reset = 1'b1; mem_ready = 1'b0; ir_ready = 1'b0; redirect = 1'b0;
    redirect_mode = 2'b00; branch_pc = '0; redirect_off = '0;
    redirect_tgt = '0; redirect_link = 1'b0;
    step(); step();

    // Reset state
    chk("rst_mem_cmd", {30'b0, mem_cmd}, 32'd0);
    chk("rst_mem_addr", {23'b0, mem_addr}, 32'd0);
    chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_link", {23'b0, link_out}, 32'd0);

    // Zero-wait streaming
    reset = 1'b0; mem_ready = 1'b1; ir_ready = 1'b1;
    step();
    chk("first_req_cmd", {30'b0, mem_cmd}, 32'd1);
    chk("first_req_addr", {23'b0, mem_addr}, 32'd0);
    chk("first_req_ir_valid", {31'b0, ir_valid}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("stream_cmd", {30'b0, mem_cmd}, 32'd1);
      chk("stream_addr", {23'b0, mem_addr}, k);
      chk("stream_ir_pc", {23'b0, ir_pc}, k - 1);
      chk("stream_ir_data", {16'b0, ir_data}, 32'hA000 | (k - 1));
    end

    // Decoder stall: exactly two pushes, then idle; resume at 2
    reset = 1'b1; step();
    reset = 1'b0; ir_ready = 1'b0; mem_ready = 1'b1;
    step(); step(); step();
    chk("stall_idle_cmd", {30'b0, mem_cmd}, 32'd0);
    step(); step(); step();
    chk("stall_still_idle", {30'b0, mem_cmd}, 32'd0);
    chk("stall_head_pc", {23'b0, ir_pc}, 32'd0);
    chk("stall_valid", {31'b0, ir_valid}, 32'd1);
    ir_ready = 1'b1;
    step();
    chk("resume_cmd", {30'b0, mem_cmd}, 32'd1);
    chk("resume_addr", {23'b0, mem_addr}, 32'd2);
    chk("resume_head_pc", {23'b0, ir_pc}, 32'd1);

    // Relative redirect with link: 5 + 1 - 3 = 3, link = 6
    strobe(2'b00, 9'd5, 9'h1FD, 9'd0, 1'b1);
    chk("rel_flush", {31'b0, ir_valid}, 32'd0);
    chk("rel_link", {23'b0, link_out}, 32'd6);
    step();
    chk("rel_req_cmd", {30'b0, mem_cmd}, 32'd1);
    chk("rel_req_addr", {23'b0, mem_addr}, 32'd3);

    // Redirect while a read is outstanding
    step(); step();
    mem_ready = 1'b0;
    step();
    held = mem_addr;
    chk("wait_cmd", {30'b0, mem_cmd}, 32'd1);
    strobe(2'b01, 9'd0, 9'd0, 9'h100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("drop_cmd", {30'b0, mem_cmd}, 32'd1);
      chk("drop_addr_held", {23'b0, mem_addr}, {23'b0, held});
      if (k < 2) step();
    end
    mem_ready = 1'b1;
    step();
    chk("drop_done_idle", {30'b0, mem_cmd}, 32'd0);
    step();
    chk("abs_req_addr", {23'b0, mem_addr}, 32'h100);

    // Return with same-strobe link write
    step();
    strobe(2'b10, 9'h20, 9'd0, 9'd0, 1'b1);
    chk("ret_link", {23'b0, link_out}, 32'h21);
    step();
    chk("ret_req_addr", {23'b0, mem_addr}, 32'd6);

    // Sequential wrap at the top of the address space
    strobe(2'b01, 9'd0, 9'd0, 9'h1FE, 1'b0);
    step();
    chk("wrap_1fe", {23'b0, mem_addr}, 32'h1FE);
    step();
    chk("wrap_1ff", {23'b0, mem_addr}, 32'h1FF);
    step();
    chk("wrap_000", {23'b0, mem_addr}, 32'h000);

    // Reset while a read is outstanding and the queue holds data
    ir_ready = 1'b0; mem_ready = 1'b0;
    step(); step();
    chk("pre_rst_cmd", {30'b0, mem_cmd}, 32'd1);
    chk("pre_rst_valid", {31'b0, ir_valid}, 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_cmd", {30'b0, mem_cmd}, 32'd0);
    chk("mid_rst_valid", {31'b0, ir_valid}, 32'd0);
    chk("mid_rst_link", {23'b0, link_out}, 32'd0);
    reset = 1'b0; mem_ready = 1'b1; ir_ready = 1'b1;
    step();
    chk("restart_addr", {23'b0, mem_addr}, 32'd0);
    chk("restart_cmd", {30'b0, mem_cmd}, 32'd1);

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      mem_ready     = ($urandom_range(0, 3) != 0);
      ir_ready      = ($urandom_range(0, 3) != 0);
      redirect      = ($urandom_range(0, 19) == 0);
      redirect_mode = 2'($urandom_range(0, 3));
      branch_pc     = AW'($urandom);
      redirect_off  = AW'($urandom);
      redirect_tgt  = AW'($urandom);
      redirect_link = $urandom_range(0, 1) == 1;
      reset         = ($urandom_range(0, 399) == 0);
      step();
    end
    redirect = 1'b0; reset = 1'b0;
    step(); step();

    chk("progress", {31'b0, (n_consumed > 100)}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
